line_span_reader: RTL

- Reader for the line buffer that the Bresenham line stage writes.
- Captures the 4096-bit edge bitmap (64x64, bit index = y*64 + x) on a start pulse.
- Raster-scans the captured copy row by row and emits every maximal run of set pixels as a span (y, x0, x1) on a valid/ready stream to the fill datapath.
- Pulses done after the last span is accepted.

---
 rtl/line_span_reader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/line_span_reader.sv
// ---------------------------------------------------------------------------
// line_span_reader
//
// Purpose:
//   Reads the edge bitmap produced by the Bresenham line stage. On a start
//   pulse the whole WIDTH x HEIGHT bitmap (bit index = y*WIDTH + x) is copied
//   into an internal buffer. The copy is raster-scanned one pixel per cycle,
//   and every maximal horizontal run of set pixels is emitted as a span
//   (y, x0, x1) to the fill datapath. Runs never continue across a row end.
//   done pulses for one cycle once the last span has been accepted.
//
// Optional build macro:
//   LSR_ROW_SKIP_EN - when defined, a row that is entirely zero is skipped
//                     in a single cycle at x=0. Span output is unchanged;
//                     only the scan time shrinks.
//
// Ports:
//   clk          in   clock, all logic on rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle scan request, honoured only when idle
//   line_buffer  in   WIDTH*HEIGHT edge bitmap, sampled when start is honoured
//   busy         out  high in every state except IDLE
//   span_valid   out  span fields valid
//   span_ready   in   consumer ready
//   span_y       out  row of the span
//   span_x0      out  first set pixel of the run
//   span_x1      out  last set pixel of the run
//   span_count   out  spans accepted in the current/last scan (saturating)
//   done         out  one-cycle pulse at end of scan
//
// Handshake: a span transfers on every rising edge where span_valid and
// span_ready are both high. Once span_valid rises, it and span_y/x0/x1 stay
// constant until that transfer happens; span_ready may be high or low at
// any time and has no effect while span_valid is low.
// ---------------------------------------------------------------------------
module line_span_reader #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  localparam int N  = WIDTH * HEIGHT,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N / 2) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  line_buffer,
  output logic          busy,
  output logic          span_valid,
  input  logic          span_ready,
  output logic [YW-1:0] span_y,
  output logic [XW-1:0] span_x0,
  output logic [XW-1:0] span_x1,
  output logic [CW-1:0] span_count,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_buf;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_in_run;
  logic          r_last_span;   // span in EMIT ended on the final pixel
  logic          r_busy;
  logic          r_valid;
  logic          r_done;
  logic [YW-1:0] r_span_y;
  logic [XW-1:0] r_span_x0;     // also serves as run-start register while scanning
  logic [XW-1:0] r_span_x1;
  logic [CW-1:0] r_count;

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_row_base;
  logic          w_bit;
  logic          w_x_end;
  logic          w_y_end;
  logic          w_last;
  logic          w_emit;
  logic          w_skip;

  assign w_row_base = IW'(r_y) << XW;
  assign w_idx      = w_row_base | IW'(r_x);
  assign w_bit      = r_buf[w_idx];
  assign w_x_end    = (r_x == XW'(WIDTH - 1));
  assign w_y_end    = (r_y == YW'(HEIGHT - 1));
  assign w_last     = w_x_end && w_y_end;
  // A run closes either on the first clear pixel after it, or at the row end.
  assign w_emit     = (w_bit && w_x_end) || (!w_bit && r_in_run);

`ifdef LSR_ROW_SKIP_EN
  // At x=0 no run can be open, so an all-zero row yields no spans.
  assign w_skip = (r_x == '0) && (r_buf[w_row_base +: WIDTH] == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_in_run    <= 1'b0;
      r_last_span <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_span_y    <= '0;
      r_span_x0   <= '0;
      r_span_x1   <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_buf    <= line_buffer;
            r_count  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_in_run <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_skip) begin
            r_y <= r_y + YW'(1);
            if (w_y_end) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            if (w_bit && !r_in_run) r_span_x0 <= r_x;
            if (w_emit) begin
              r_span_x1   <= w_bit ? r_x : r_x - XW'(1);
              r_span_y    <= r_y;
              r_in_run    <= 1'b0;
              r_valid     <= 1'b1;
              r_last_span <= w_last;
              r_state     <= S_EMIT;
            end else if (w_bit) begin
              r_in_run <= 1'b1;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
            // Pointer always advances; EMIT resumes at the saved position.
            r_x <= r_x + XW'(1);
            if (w_x_end) r_y <= r_y + YW'(1);
          end
        end

        S_EMIT: begin
          if (span_ready) begin
            r_valid <= 1'b0;
            if (r_count != '1) r_count <= r_count + CW'(1);
            if (r_last_span) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign span_valid = r_valid;
  assign span_y     = r_span_y;
  assign span_x0    = r_span_x0;
  assign span_x1    = r_span_x1;
  assign span_count = r_count;
  assign done       = r_done;

endmodule
